// File: rtl/audio_i2s_tx.sv
// I2S stereo transmitter: an 8-deep FIFO of {left,right} words, serialised MSB first
// with the standard one-BCLK delay after each word-select change.
module audio_i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    input  logic                  enable,
    input  logic                  underrun_clr,
    output logic                  i2s_bclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdata,
    output logic [3:0]            fifo_level,
    output logic                  underrun
);

    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    DEPTH_L  = 4'(FIFO_DEPTH);
    localparam logic [7:0]    DIV_LAST = 8'(BCLK_DIV - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_FILL = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    logic [1:0]        state;
    logic [7:0]        div_cnt;
    logic [4:0]        slot;
    logic              stopping;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [3:0]        level;

    logic fifo_empty;
    logic bclk_fall;
    logic frame_wrap;
    logic pop_first;
    logic pop_run;
    logic pop;
    logic push;
    logic [WORD_W-1:0] rd_data;
    logic [4:0]        next_slot;

    // Ready is forced low while reset is held so nothing is taken during reset.
    assign s_ready    = ARESETN & (level < DEPTH_L);
    assign fifo_level = level;
    assign fifo_empty = (level == 4'd0);
    assign push       = s_valid & s_ready;
    assign rd_data    = mem[rd_ptr];
    assign next_slot  = slot + 5'd1;

    assign bclk_fall  = (state == RUN) && (div_cnt == DIV_LAST) && i2s_bclk;
    assign frame_wrap = bclk_fall && (slot == 5'd31);
    assign pop_first  = (state == WAIT_FILL) && enable && !fifo_empty;
    assign pop_run    = frame_wrap && !stopping && enable && !fifo_empty;
    assign pop        = pop_first | pop_run;

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= {s_left, s_right};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 4'd1;
                2'b01:   level <= level - 4'd1;
                default: level <= level;
            endcase
        end
    end

    // A slot-0 entry with enable high but nothing queued sends a silent word.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            underrun <= 1'b0;
        end else if (frame_wrap && !stopping && enable && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            div_cnt   <= 8'd0;
            slot      <= 5'd0;
            stopping  <= 1'b0;
            cur_word  <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_sdata <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt   <= 8'd0;
                    slot      <= 5'd0;
                    stopping  <= 1'b0;
                    i2s_bclk  <= 1'b0;
                    i2s_lrck  <= 1'b0;
                    i2s_sdata <= 1'b0;
                    if (enable) begin
                        state <= WAIT_FILL;
                    end
                end
                WAIT_FILL: begin
                    div_cnt   <= 8'd0;
                    slot      <= 5'd0;
                    i2s_bclk  <= 1'b0;
                    i2s_lrck  <= 1'b0;
                    i2s_sdata <= 1'b0;
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!fifo_empty) begin
                        state    <= RUN;
                        cur_word <= rd_data;
                    end
                end
                RUN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= 8'd0;
                        i2s_bclk <= ~i2s_bclk;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                    // Data and word select only move on BCLK falling edges.
                    if (bclk_fall) begin
                        if (stopping) begin
                            state     <= IDLE;
                            stopping  <= 1'b0;
                            slot      <= 5'd0;
                            i2s_lrck  <= 1'b0;
                            i2s_sdata <= 1'b0;
                        end else begin
                            slot     <= next_slot;
                            i2s_lrck <= next_slot[4];
                            if (slot == 5'd31) begin
                                i2s_sdata <= cur_word[0];
                                if (enable) begin
                                    cur_word <= fifo_empty ? '0 : rd_data;
                                end else begin
                                    stopping <= 1'b1;
                                end
                            end else begin
                                i2s_sdata <= cur_word[5'd31 - slot];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: an I2S receiver model samples sdata/lrck on
// BCLK rising edges and compares against words tracked in a queue.
module tb_audio_i2s_tx;

    localparam int BCLK_DIV = 2;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic        enable = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic [3:0]  fifo_level;
    logic        underrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [31:0] q[$];

    audio_i2s_tx #(.DATA_WIDTH(16), .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .enable(enable), .underrun_clr(underrun_clr),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
        .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic do_reset();
        @(negedge ACLK);
        ARESETN = 1'b0;
        enable = 1'b0;
        s_valid = 1'b0;
        q.delete();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic push_word(input logic [31:0] w);
        s_valid = 1'b1;
        s_left = w[31:16];
        s_right = w[15:0];
        @(negedge ACLK);
        s_valid = 1'b0;
        q.push_back(w);
    endtask

    // Waits for the next BCLK rising edge, as an I2S receiver would latch data.
    task automatic rx_slot(output logic sd, output logic lr, output logic ur, output int rise_cyc);
        logic prev;
        logic found;
        int n;
        prev = i2s_bclk;
        found = 1'b0;
        n = 0;
        sd = 1'b0; lr = 1'b0; ur = 1'b0; rise_cyc = -1;
        while (!found && n < 100) begin
            @(negedge ACLK);
            n++;
            if (!prev && i2s_bclk) begin
                found = 1'b1;
                sd = i2s_sdata; lr = i2s_lrck; ur = underrun; rise_cyc = cyc;
            end
            prev = i2s_bclk;
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("[TB] FAIL bclk_timeout: no bclk rise within %0d cycles, required one", n);
        end
    endtask

    task automatic check_frame(input logic [31:0] w, input logic prev_lsb, input logic first,
                               input int drop_at, input logic ur_init, input int clr_at,
                               input logic [3:0] lvl);
        logic sd, lr, ur, exp_sd, exp_ur;
        int rc, last_rc;
        exp_ur = ur_init;
        last_rc = -1;
        for (int k = 0; k < 32; k++) begin
            rx_slot(sd, lr, ur, rc);
            exp_sd = (k == 0) ? prev_lsb : w[32 - k];
            vectors++;
            if (sd !== exp_sd) begin
                miscompares++;
                $display("[TB] FAIL sdata slot %0d word %h: got %b expected %b", k, w, sd, exp_sd);
            end
            vectors++;
            if (lr !== (k >= 16)) begin
                miscompares++;
                $display("[TB] FAIL lrck slot %0d: got %b expected %b", k, lr, (k >= 16));
            end
            vectors++;
            if (ur !== exp_ur) begin
                miscompares++;
                $display("[TB] FAIL underrun slot %0d: got %b expected %b", k, ur, exp_ur);
            end
            if (k > 0 || !first) begin
                vectors++;
                if (last_rc >= 0 && rc - last_rc !== 2 * BCLK_DIV) begin
                    miscompares++;
                    $display("[TB] FAIL bclk_period slot %0d: got %0d expected %0d", k, rc - last_rc, 2 * BCLK_DIV);
                end
            end
            if (k == 1) begin
                vectors++;
                if (fifo_level !== lvl) begin
                    miscompares++;
                    $display("[TB] FAIL level_in_frame: got %0d expected %0d", fifo_level, lvl);
                end
            end
            last_rc = rc;
            if (k == drop_at) enable = 1'b0;
            if (k == clr_at) begin
                underrun_clr = 1'b1;
                @(negedge ACLK);
                underrun_clr = 1'b0;
                exp_ur = 1'b0;
            end
        end
    endtask

    // Trailing slot 0 carries the last LSB, then the link must park idle.
    task automatic finish_stop(input logic last_lsb, input logic [3:0] lvl, input logic exp_ur);
        logic sd, lr, ur;
        int rc;
        int rises;
        logic prev;
        rx_slot(sd, lr, ur, rc);
        vectors++;
        if (sd !== last_lsb || lr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stop_slot0: got sd=%b lr=%b expected sd=%b lr=0", sd, lr, last_lsb);
        end
        repeat (4 * BCLK_DIV) @(negedge ACLK);
        vectors++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs: got %b expected 000", {i2s_bclk, i2s_lrck, i2s_sdata});
        end
        rises = 0;
        prev = i2s_bclk;
        repeat (8 * BCLK_DIV) begin
            @(negedge ACLK);
            if (!prev && i2s_bclk) rises++;
            prev = i2s_bclk;
        end
        vectors++;
        if (rises !== 0) begin
            miscompares++;
            $display("[TB] FAIL idle_bclk: got %0d rises expected 0", rises);
        end
        vectors++;
        if (fifo_level !== lvl) begin
            miscompares++;
            $display("[TB] FAIL idle_level: got %0d expected %0d", fifo_level, lvl);
        end
        vectors++;
        if (underrun !== exp_ur) begin
            miscompares++;
            $display("[TB] FAIL idle_underrun: got %b expected %b", underrun, exp_ur);
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, underrun, s_ready} !== 5'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b level %0d expected 00000 level 0",
                     {i2s_bclk, i2s_lrck, i2s_sdata, underrun, s_ready}, fifo_level);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", s_ready);
        end
        @(negedge ACLK);
    endtask

    task automatic test_fill();
        logic [31:0] w;
        int model_cnt;
        model_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            w = $urandom;
            s_valid = 1'b1;
            s_left = w[31:16];
            s_right = w[15:0];
            #1;
            vectors++;
            if (s_ready !== (model_cnt < 8)) begin
                miscompares++;
                $display("[TB] FAIL fill_ready word %0d: got %b expected %b", i, s_ready, (model_cnt < 8));
            end
            vectors++;
            if (fifo_level !== 4'(model_cnt)) begin
                miscompares++;
                $display("[TB] FAIL fill_level word %0d: got %0d expected %0d", i, fifo_level, model_cnt);
            end
            if (model_cnt < 8) model_cnt++;
            @(negedge ACLK);
        end
        s_valid = 1'b0;
        vectors++;
        if (fifo_level !== 4'd8 || s_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_full: got level %0d ready %b expected level 8 ready 0", fifo_level, s_ready);
        end
        do_reset();
        vectors++;
        if (fifo_level !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_discard: got level %0d expected 0", fifo_level);
        end
    endtask

    task automatic test_stream();
        int n;
        do_reset();
        push_word(32'hA5A5_3C3C);
        push_word($urandom);
        push_word($urandom);
        n = q.size();
        enable = 1'b1;
        for (int f = 0; f < n; f++) begin
            check_frame(q[f], (f == 0) ? 1'b0 : q[f-1][0], (f == 0), (f == n - 1) ? 5 : -1,
                        1'b0, -1, 4'(n - 1 - f));
        end
        finish_stop(q[n-1][0], 4'd0, 1'b0);
    endtask

    task automatic test_underrun();
        do_reset();
        push_word($urandom);
        enable = 1'b1;
        check_frame(q[0], 1'b0, 1'b1, -1, 1'b0, -1, 4'd0);
        check_frame(32'h0, q[0][0], 1'b0, 12, 1'b1, 8, 4'd0);
        finish_stop(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_stop_mid_frame();
        do_reset();
        repeat (3) push_word($urandom);
        enable = 1'b1;
        check_frame(q[0], 1'b0, 1'b1, 10, 1'b0, -1, 4'd2);
        finish_stop(q[0][0], 4'd2, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic sd, lr, ur;
        int rc;
        enable = 1'b1;
        for (int k = 0; k <= 20; k++) rx_slot(sd, lr, ur, rc);
        #2;
        ARESETN = 1'b0;
        #1;
        vectors++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, s_ready} !== 4'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %b level %0d expected 0000 level 0",
                     {i2s_bclk, i2s_lrck, i2s_sdata, s_ready}, fifo_level);
        end
        enable = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        q.delete();
        repeat (3) @(negedge ACLK);
        vectors++;
        if (fifo_level !== 4'd0 || i2s_bclk !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got level %0d bclk %b expected 0 0", fifo_level, i2s_bclk);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_underrun();
        test_stop_mid_frame();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
